// File: rtl/fifo_pkg.sv
// Shared helpers for the parametrised synchronous FIFO: width derivation
// and parameter legality checks used at elaboration time.
package fifo_pkg;

  // Ceiling log2, valid for value >= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // True when value is a positive power of two.
  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  // Depth must be a power of two (pointers wrap naturally) and at least 4;
  // thresholds must leave almost_empty strictly below almost_full.
  function automatic bit params_legal(input int depth, input int af_level,
                                      input int ae_level);
    return is_pow2(depth) && (depth >= 4) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W register array, one synchronous write port
// and one asynchronous read port. Contents are never reset.
module fifo_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Store the incoming word at the write pointer on an accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, registered overflow/underflow pulses and optional FWFT output.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0,
  localparam int PTR_W   = clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] d_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] d_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  if (!params_legal(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
    $error("fifo_sync_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] mem_rdata;

  // Accept decisions look only at this cycle's registered flags, so a read
  // on a full FIFO never frees a slot for a same-cycle write (and vice versa).
  assign wr_acc = en & wr_en & ~full_q;
  assign rd_acc = en & rd_en & ~empty_q;

  // Next pointers, count, flags decoded from the next count, and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_acc);
    count_d  = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    full_d   = (count_d == CNT_W'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CNT_W'(AF_LEVEL));
    aempty_d = (count_d <= CNT_W'(AE_LEVEL));
    ovf_d    = en & wr_en & full_q;
    unf_d    = en & rd_en & empty_q;
  end

  // Control state register; with en=0 every _d equals its _q, so state holds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (d_in),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  if (FWFT == 0) begin : g_std
    logic [DATA_W-1:0] dout_q;

    // Registered read: capture the head word on an accepted read, else hold.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_rdata;
      end
    end

    assign d_out = dout_q;
  end else begin : g_fwft
    // Head word is presented directly; zero while nothing is stored.
    assign d_out = empty_q ? '0 : mem_rdata;
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench: a standard-mode and an FWFT-mode FIFO, each checked
// every cycle against a queue-based reference model.
module tb_fifo_sync_param;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clk;
  logic          reset;
  logic          en;
  logic          wr_en, rd_en;
  logic          wr_en_f, rd_en_f;
  logic [DW-1:0] d_in;

  logic [DW-1:0] d_out_s, d_out_f;
  logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
  logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
  logic [4:0]    count_s, count_f;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_f[$];
  logic [DW-1:0] m_dout_s;
  bit            m_ovf_s, m_unf_s, m_ovf_f, m_unf_f;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en), .d_in(d_in), .rd_en(rd_en),
    .d_out(d_out_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
    .almost_empty(ae_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
  );

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .en(en), .wr_en(wr_en_f), .d_in(d_in), .rd_en(rd_en_f),
    .d_out(d_out_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
    .almost_empty(ae_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_s.delete();
    q_f.delete();
    m_dout_s = '0;
    m_ovf_s = 0; m_unf_s = 0; m_ovf_f = 0; m_unf_f = 0;
  endtask

  task automatic check_all();
    int ns;
    int nf;
    logic [DW-1:0] exp_f;
    ns = q_s.size();
    nf = q_f.size();
    exp_f = (nf > 0) ? q_f[0] : '0;
    check("s_count", DW'(count_s), DW'(ns));
    check("s_empty", DW'(empty_s), DW'(ns == 0));
    check("s_full",  DW'(full_s),  DW'(ns == DEPTH));
    check("s_afull", DW'(af_s),    DW'(ns >= AF));
    check("s_aempty", DW'(ae_s),   DW'(ns <= AE));
    check("s_ovf",   DW'(ovf_s),   DW'(m_ovf_s));
    check("s_unf",   DW'(unf_s),   DW'(m_unf_s));
    check("s_dout",  d_out_s,      m_dout_s);
    check("f_count", DW'(count_f), DW'(nf));
    check("f_empty", DW'(empty_f), DW'(nf == 0));
    check("f_full",  DW'(full_f),  DW'(nf == DEPTH));
    check("f_ovf",   DW'(ovf_f),   DW'(m_ovf_f));
    check("f_unf",   DW'(unf_f),   DW'(m_unf_f));
    check("f_dout",  d_out_f,      exp_f);
  endtask

  // One clock of stimulus; the model applies the FIFO rules to its queues.
  task automatic step(input bit e, input bit ws, input bit rs, input bit wf,
                      input bit rf, input logic [DW-1:0] d);
    int ns;
    int nf;
    en = e; wr_en = ws; rd_en = rs; wr_en_f = wf; rd_en_f = rf; d_in = d;
    @(posedge clk);
    ns = q_s.size();
    nf = q_f.size();
    m_ovf_s = e && ws && (ns == DEPTH);
    m_unf_s = e && rs && (ns == 0);
    if (e && rs && ns > 0) m_dout_s = q_s.pop_front();
    if (e && ws && ns < DEPTH) q_s.push_back(d);
    m_ovf_f = e && wf && (nf == DEPTH);
    m_unf_f = e && rf && (nf == 0);
    if (e && rf && nf > 0) void'(q_f.pop_front());
    if (e && wf && nf < DEPTH) q_f.push_back(d);
    #1;
    check_all();
    $display("t=%0t en=%0b wr=%0b rd=%0b wrf=%0b rdf=%0b din=%08h cnt=%0d dout=%08h cntf=%0d doutf=%08h",
             $time, e, ws, rs, wf, rf, d, count_s, d_out_s, count_f, d_out_f);
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    wr_en_f = 1'b0; rd_en_f = 1'b0; d_in = '0;
    model_clear();

    // 1. Reset state, then asynchronous reset in the middle of a fill
    #100;
    reset = 1'b0;
    en = 1'b1;
    #1;
    check_all();
    for (int i = 0; i < 7; i++) step(1, 1, 0, 0, 0, DW'(32'h50 + i));
    check("fill7_count", DW'(count_s), 32'd7);
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    check("async_rst_count", DW'(count_s), 32'd0);
    check("async_rst_empty", DW'(empty_s), 32'd1);
    check_all();
    #1;
    reset = 1'b0;

    // 2. Standard write 0..4 then read them back
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, DW'(i));
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 1, 0, 0, '0);
      check("seq_dout", d_out_s, DW'(i));
    end

    // 3. Fill to full, overflow attempt, drain
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0, DW'(32'h100 + i));
    step(1, 1, 0, 0, 0, 32'h1FF);
    check("ovf_pulse", DW'(ovf_s), 32'd1);
    step(1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 1, 0, 0, '0);
      check("drain_dout", d_out_s, DW'(32'h100 + i));
    end

    // 4. Underflow, simultaneous access at count 5 and at full
    step(1, 0, 1, 0, 0, '0);
    check("unf_pulse", DW'(unf_s), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, DW'(32'h200 + i));
    step(1, 1, 1, 0, 0, 32'h205);
    for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 0, DW'(32'h206 + i));
    step(1, 1, 1, 0, 0, 32'h2FF);
    check("full_rw_count", DW'(count_s), 32'd15);
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0, '0);

    // 5. en=0 freeze at count 3
    for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 1, 32'hDEAD);
    check("freeze_count", DW'(count_s), 32'd3);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, '0);

    // 6. FWFT instance
    step(1, 0, 0, 1, 0, 32'hA5);
    check("fwft_show", d_out_f, 32'hA5);
    step(1, 0, 0, 1, 0, 32'h5A);
    step(1, 0, 0, 0, 1, '0);
    check("fwft_pop", d_out_f, 32'h5A);
    step(1, 0, 0, 0, 1, '0);
    check("fwft_empty_dout", d_out_f, 32'h0);

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 400; i++) begin
      bit b;
      b = ((i / 40) % 2) == 0;
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 99) < (b ? 75 : 30),
           $urandom_range(0, 99) < (b ? 30 : 75),
           $urandom_range(0, 99) < (b ? 70 : 35),
           $urandom_range(0, 99) < (b ? 35 : 70),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO. It is the successor to the fixed 32-bit FIFO_Sync and keeps the same port style (clk, reset, en, wr_en, rd_en, d_in, d_out, full, empty). It adds configurable width and depth, almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) mode. It is used as the general buffering element between datapath stages in one clock domain.

Parameters:
DATA_W, 32, data word width in bits
DEPTH, 16, number of entries; power of 2, >= 4
AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = registered read (standard), 1 = first-word-fall-through

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  global enable; 0 freezes all state
wr_en  in  1  write request
d_in  in  DATA_W  write data
rd_en  in  1  read request (in FWFT mode: pop acknowledge)
d_out  out  DATA_W  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- Reset (reset=1, asynchronous, immediate, takes priority over everything):
  - wr_ptr=0, rd_ptr=0, count=0, d_out=0.
  - empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
  - Storage array is not cleared; contents are discarded logically.
  - Reset mid-operation drops all stored words.
- en=0: pointers, count, d_out and flags hold. Requests are ignored and overflow/underflow stay 0.
- Acceptance, with en=1:
  - Write accepted iff wr_en & !full.
  - Read accepted iff rd_en & !empty.
  - Each decision uses only the current-cycle flags. A read on a full FIFO does not free a slot for a write in the same cycle, and a write on an empty FIFO does not feed a read in the same cycle.
- Error pulses: overflow=1 for exactly the cycle after an edge where wr_en & full & en; likewise underflow for rd_en & empty & en. Both are registered.
- Pointers: $clog2(DEPTH) bits each, increment on accept, wrap DEPTH-1 -> 0 naturally.
- Count: registered.
  - +1 on write only, -1 on read only.
  - Unchanged when both or neither are accepted.
  - All flags are registered, decoded from the next count value, and valid in the same cycle as count.
- Standard mode (FWFT=0):
  - On an accepted read edge, d_out <= mem[rd_ptr]; the value is visible after that edge. One-cycle read latency.
  - d_out holds between reads.
  - A word written at edge N clears empty after edge N and can be read at edge N+1.
- FWFT mode (FWFT=1):
  - d_out = mem[rd_ptr] when !empty, else 0.
  - A word written at edge N appears on d_out after edge N.
  - rd_en pops the head, and the next word appears after the pop edge.
- Ordering is strict FIFO.

Decomposition:
- Package fifo_pkg holds:
  - clog2 helper / PTR_W, CNT_W derivation;
  - parameter legality checks (DEPTH power of 2, AE_LEVEL < AF_LEVEL <= DEPTH).
- Sub-module fifo_mem: DEPTH x DATA_W register array with one synchronous write port and one asynchronous read address port.
- fifo_sync_param holds the pointers, count, flags, error pulses and the d_out register/mux.

Test Plan:
1. Assert reset for 100 ns with en=0, then en=1 -> d_out=0, empty=1, almost_empty=1, full=0, count=0. Mid-fill at count=7, pulse reset between edges -> count=0 and empty=1 immediately, before the next edge.
2. Standard mode: write 0x0..0x4 on consecutive cycles, then rd_en=1 for 5 cycles -> d_out = 0,1,2,3,4 one cycle after each read edge; count 5 -> 0; empty=1 after the 5th read; almost_empty rises when count=2.
3. Write 0x100..0x10F -> almost_full rises at count=14 and full at 16. A 17th write (0x1FF) -> overflow high for one cycle, count stays 16, and the later readout is 0x100..0x10F with no 0x1FF.
4. Read while empty -> underflow pulses one cycle, d_out holds its previous value, count=0. Simultaneous wr/rd at count=5 -> count stays 5 and order is preserved. Simultaneous wr/rd at full -> count=15, overflow=1.
5. At count=3, hold en=0 with wr_en=1 and rd_en=1 for 3 cycles -> count=3, d_out unchanged, no error pulses.
6. FWFT=1 instance: write 0xA5 at edge N -> d_out=0xA5 and empty=0 after edge N with no rd_en. Write 0x5A, then pop once -> d_out=0x5A. Pop again -> empty=1, d_out=0.
